bus_wdemux8_32: RTL and testbench
=================================

# bus_wdemux8_32

Write-side bus distributor for the multicycle CPU SoC: accepts one 32-bit bus request from the CPU and forwards it to exactly one of eight peripheral slots, selected by three address bits. It issues a one-hot strobe and waits for that slot's acknowledge, with a bounded timeout. It then reports completion or error to the CPU. It also supplies the registered slot select that drives the read-data 8-to-1 mux, so request and return paths stay aligned.

## Interface
- TIMEOUT, 15: max cycles strobe is held awaiting ack (legal 2..255)
- SEL_LSB, 28: m_addr[SEL_LSB+2:SEL_LSB] is the slot index (legal 0..29)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m_req  in  1  CPU request, sampled only in IDLE
- m_we  in  1  write (1) / read (0)
- m_addr  in  32  request address
- m_wdata  in  32  write data
- m_busy  out  1  transaction in flight (WAIT or DONE)
- m_done  out  1  one-cycle completion pulse
- m_err  out  1  one-cycle timeout flag, only coincident with m_done
- sel_o  out  3  latched slot index, drives read-data mux select
- s_stb  out  8  one-hot slot strobe
- s_we  out  1  latched m_we
- s_addr  out  32  latched m_addr
- s_wdata  out  32  latched m_wdata
- s_ack  in  8  per-slot acknowledge

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE.
- IDLE, m_req=1: latch m_we/m_addr/m_wdata into s_we/s_addr/s_wdata, sel_o ← m_addr[SEL_LSB+2:SEL_LSB], s_stb ← onehot(sel), counter ← 0, → WAIT.
- IDLE, m_req=0: hold. Latched outputs and sel_o keep last value.
- WAIT: s_stb held. Only s_ack[sel_o] is observed; other ack bits are ignored.
  - s_ack[sel_o]=1: s_stb ← 0, m_done ← 1, m_err ← 0, → DONE.
  - No ack, counter == TIMEOUT-1: s_stb ← 0, m_done ← 1, m_err ← 1, → DONE.
  - Otherwise counter += 1 (8-bit, never wraps because of TIMEOUT bound).
- DONE: m_done/m_err cleared at next edge, → IDLE. m_req is ignored in DONE.
- m_req while m_busy=1 is ignored, with no queueing. The CPU must hold or re-issue the request.
- Ack and timeout in the same cycle: ack wins, m_err=0.
- Reset mid-transaction: at the next edge s_stb=0, m_done=0, m_err=0, state IDLE. No completion is reported.
- The block performs no read-data handling. Read data returns through the external mux using sel_o, which stays stable from accept until the next accept.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values: s_stb=0, s_we=0, s_addr=0, s_wdata=0, sel_o=0, m_busy=0, m_done=0, m_err=0, counter=0.
- Cycle 0: m_req sampled in IDLE. Cycle 1: s_stb valid and m_busy=1.
- Ack sampled at cycle k≥1 → cycle k+1: s_stb=0, m_done=1. Cycle k+2: m_busy=0, new request accepted.
- Minimum turnaround: 3 cycles request-to-request (ack at cycle 1).
- Timeout: the strobe is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT). m_done=m_err=1 at cycle TIMEOUT+1.

## Structure
- Shared package `bus_pkg`: state enum (IDLE/WAIT/DONE), NSLOT=8, SEL_W=3, one-hot decode function.
- One sub-module, `wait_timer`: clear, enable, TIMEOUT compare, expire output. The FSM, latches and strobe stay in the top level.

## Test plan
- Write to m_addr=0x3000_0010, m_wdata=0xDEAD_BEEF, slot 3 acks at cycle 2 → s_stb=0x08 during cycles 1–2, s_wdata=0xDEAD_BEEF. m_done pulses at cycle 3 with m_err=0, m_busy=0 at cycle 4.
- Read to slot 7 (m_addr=0x7000_0000), no ack, TIMEOUT=15 → s_stb=0x80 for 15 cycles, m_done=m_err=1 at cycle 16, sel_o=7 held after.
- Slot 5 active, s_ack=0x02 (wrong slot) for 3 cycles, then 0x20 → the wrong-slot ack is ignored and done follows the first s_ack[5].
- m_req held high continuously, slot 0 acks immediately → accepts every 3 cycles, no request accepted while m_busy=1.
- rst asserted in WAIT (cycle 4) → s_stb=0 next edge, m_done never pulses, a new request is accepted the cycle after rst deasserts.
- Ack arrives on the timeout cycle (cycle 15, TIMEOUT=15) → m_done=1, m_err=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the write-side bus distributor: FSM states,
// slot count and the slot-index to one-hot strobe decode.
package bus_pkg;

    localparam int unsigned NSLOT = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [NSLOT-1:0] onehot(input logic [SEL_W-1:0] s);
        return NSLOT'(1) << s;
    endfunction

endpackage

// File: rtl/bus_wdemux8_32_wait_timer.sv
// Acknowledge wait counter: expire is raised while the count sits at the
// last permitted strobe cycle (TIMEOUT-1).
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_wdemux8_32.sv
// Routes one CPU bus request to one of eight slots, waits for that slot's
// ack (bounded by TIMEOUT) and reports done/error; all outputs registered.
module bus_wdemux8_32 #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned SEL_LSB = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_busy,
    output logic        m_done,
    output logic        m_err,
    output logic [2:0]  sel_o,
    output logic [7:0]  s_stb,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [7:0]  s_ack
);

    import bus_pkg::*;

    state_t             state_q, state_d;
    logic               busy_d, done_d, err_d, we_d;
    logic [SEL_W-1:0]   sel_d;
    logic [NSLOT-1:0]   stb_d;
    logic [31:0]        addr_d, wdata_d;
    logic               ack_sel, expire;

    // Only the addressed slot's ack counts; stray acks from others are ignored.
    assign ack_sel = s_ack[sel_o];

    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != WAIT),
        .en     ((state_q == WAIT) && !ack_sel && !expire),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        stb_d   = s_stb;
        sel_d   = sel_o;
        we_d    = s_we;
        addr_d  = s_addr;
        wdata_d = s_wdata;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    sel_d   = m_addr[SEL_LSB+2:SEL_LSB];
                    stb_d   = onehot(sel_d);
                    we_d    = m_we;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ack_sel) begin
                    stb_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (expire) begin
                    stb_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            sel_o   <= '0;
            s_stb   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
        end else begin
            state_q <= state_d;
            m_busy  <= busy_d;
            m_done  <= done_d;
            m_err   <= err_d;
            sel_o   <= sel_d;
            s_stb   <= stb_d;
            s_we    <= we_d;
            s_addr  <= addr_d;
            s_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_bus_wdemux8_32.sv
// Directed bench for bus_wdemux8_32: handshake, timeout, wrong-slot acks,
// back-to-back requests, mid-transaction reset and ack-vs-timeout priority.
module tb_bus_wdemux8_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_busy, m_done, m_err;
    logic [2:0]  sel_o;
    logic [7:0]  s_stb;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [7:0]  s_ack;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    bus_wdemux8_32 #(.TIMEOUT(15), .SEL_LSB(28)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_busy  (m_busy),
        .m_done  (m_done),
        .m_err   (m_err),
        .sel_o   (sel_o),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; m_req = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; s_ack = '0;
        tick(); tick();
        chk("rst_stb", 32'(s_stb), 32'h0);
        chk("rst_busy", 32'(m_busy), 32'h0);
        chk("rst_done", 32'(m_done), 32'h0);
        chk("rst_err", 32'(m_err), 32'h0);
        chk("rst_sel", 32'(sel_o), 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_wdata", s_wdata, 32'h0);
        chk("rst_we", 32'(s_we), 32'h0);
        rst = 1'b0;
        tick();

        // Write to slot 3, ack at cycle 2
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h3000_0010; m_wdata = 32'hDEAD_BEEF;
        tick();                                   // cycle 1
        m_req = 1'b0; m_wdata = 32'h0;
        chk("w_c1_stb", 32'(s_stb), 32'h08);
        chk("w_c1_busy", 32'(m_busy), 32'h1);
        chk("w_c1_sel", 32'(sel_o), 32'h3);
        chk("w_c1_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("w_c1_addr", s_addr, 32'h3000_0010);
        chk("w_c1_we", 32'(s_we), 32'h1);
        tick();                                   // cycle 2
        chk("w_c2_stb", 32'(s_stb), 32'h08);
        chk("w_c2_done", 32'(m_done), 32'h0);
        s_ack = 8'h08;
        tick();                                   // cycle 3
        s_ack = 8'h00;
        chk("w_c3_stb", 32'(s_stb), 32'h0);
        chk("w_c3_done", 32'(m_done), 32'h1);
        chk("w_c3_err", 32'(m_err), 32'h0);
        tick();                                   // cycle 4
        chk("w_c4_busy", 32'(m_busy), 32'h0);
        chk("w_c4_done", 32'(m_done), 32'h0);

        // Read to slot 7, no ack: timeout after 15 strobe cycles
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h7000_0000;
        tick();                                   // cycle 1
        m_req = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk($sformatf("to_stb_c%0d", c), 32'(s_stb), 32'h80);
            chk($sformatf("to_done_c%0d", c), 32'(m_done), 32'h0);
            tick();
        end                                       // cycle 16
        chk("to_c16_done", 32'(m_done), 32'h1);
        chk("to_c16_err", 32'(m_err), 32'h1);
        chk("to_c16_stb", 32'(s_stb), 32'h0);
        tick();
        chk("to_c17_busy", 32'(m_busy), 32'h0);
        chk("to_c17_err", 32'(m_err), 32'h0);
        chk("to_c17_sel", 32'(sel_o), 32'h7);
        chk("to_we", 32'(s_we), 32'h0);
        tick();
        chk("to_c18_sel", 32'(sel_o), 32'h7);

        // Slot 5 with wrong-slot acks for 3 cycles
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h5000_0000; m_wdata = 32'h1234_5678;
        tick();                                   // cycle 1
        m_req = 1'b0;
        s_ack = 8'h02;
        chk("ws_c1_stb", 32'(s_stb), 32'h20);
        tick(); tick(); tick();                   // cycle 4
        chk("ws_c4_done", 32'(m_done), 32'h0);
        chk("ws_c4_stb", 32'(s_stb), 32'h20);
        s_ack = 8'h20;
        tick();                                   // cycle 5
        s_ack = 8'h00;
        chk("ws_c5_done", 32'(m_done), 32'h1);
        chk("ws_c5_err", 32'(m_err), 32'h0);
        tick();

        // Continuous request to slot 0 with ack held: accept every 3 cycles
        m_req = 1'b1; m_addr = 32'h0000_0004; s_ack = 8'h01;
        for (int i = 0; i < 9; i++) begin
            m_wdata = 32'h100 + 32'(i);
            tick();
            chk($sformatf("bb_wdata_%0d", i), s_wdata, 32'h100 + 32'((i / 3) * 3));
            chk($sformatf("bb_stb_%0d", i), 32'(s_stb), (i % 3 == 0) ? 32'h01 : 32'h0);
            chk($sformatf("bb_done_%0d", i), 32'(m_done), (i % 3 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("bb_busy_%0d", i), 32'(m_busy), (i % 3 == 2) ? 32'h0 : 32'h1);
        end
        m_req = 1'b0; s_ack = 8'h00;

        // Reset asserted at cycle 4 of a transaction to slot 2
        m_addr = 32'h2000_0000; m_req = 1'b1;
        tick();                                   // cycle 1
        m_req = 1'b0;
        chk("rs_c1_stb", 32'(s_stb), 32'h04);
        tick(); tick(); tick();                   // cycle 4
        rst = 1'b1;
        tick();                                   // cycle 5
        chk("rs_stb", 32'(s_stb), 32'h0);
        chk("rs_done", 32'(m_done), 32'h0);
        chk("rs_busy", 32'(m_busy), 32'h0);
        chk("rs_addr", s_addr, 32'h0);
        rst = 1'b0; m_req = 1'b1; m_addr = 32'h6000_0000;
        tick();
        m_req = 1'b0;
        chk("rs_new_stb", 32'(s_stb), 32'h40);
        chk("rs_new_done", 32'(m_done), 32'h0);
        chk("rs_new_sel", 32'(sel_o), 32'h6);
        s_ack = 8'h40;
        tick();
        s_ack = 8'h00;
        chk("rs_new_cmp", 32'(m_done), 32'h1);
        tick();

        // Ack coincides with the timeout cycle: ack wins
        m_req = 1'b1; m_addr = 32'h1000_0000;
        tick();                                   // cycle 1
        m_req = 1'b0;
        for (int c = 1; c < 15; c++) begin
            chk($sformatf("at_done_c%0d", c), 32'(m_done), 32'h0);
            tick();
        end                                       // cycle 15
        chk("at_c15_stb", 32'(s_stb), 32'h02);
        s_ack = 8'h02;
        tick();                                   // cycle 16
        s_ack = 8'h00;
        chk("at_c16_done", 32'(m_done), 32'h1);
        chk("at_c16_err", 32'(m_err), 32'h0);
        chk("at_c16_stb", 32'(s_stb), 32'h0);
        tick();
        chk("at_c17_busy", 32'(m_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
